// File: rtl/console_pkg.sv
// Shared console geometry, request opcodes and the cell address helper used by
// both the console writer and the display driver.
package console_pkg;

   localparam int COLS  = 40;
   localparam int ROWS  = 30;
   localparam int CELLS = 1200;

   typedef enum logic [1:0] {
      OP_PUTC    = 2'd0,
      OP_NEWLINE = 2'd1,
      OP_CLEAR   = 2'd2,
      OP_HOME    = 2'd3
   } op_t;

   // row*40 + col built from shifts so both consumers share identical arithmetic.
   function automatic logic [10:0] cell_addr(input logic [4:0] row, input logic [5:0] col);
      return {1'b0, row, 5'b0} + {3'b0, row, 3'b0} + {5'b0, col};
   endfunction

endpackage

// File: rtl/console_writer_if.sv
// Request handshake from the processor console port plus the screen-memory write port.
// Handshake: a request transfers on a clk edge where req_valid && req_ready; the
// requester holds req_valid/req_op/req_char stable until that edge, and req_ready
// never depends on req_valid.
interface console_writer_if;

   logic        req_valid;
   logic [1:0]  req_op;
   logic [3:0]  req_char;
   logic        req_ready;
   logic        smem_wr;
   logic [10:0] smem_addr;
   logic [3:0]  smem_wdata;

   modport master (
      output req_valid, req_op, req_char,
      input  req_ready, smem_wr, smem_addr, smem_wdata
   );

   modport slave (
      input  req_valid, req_op, req_char,
      output req_ready, smem_wr, smem_addr, smem_wdata
   );

endinterface

// File: rtl/console_writer.sv
// Text console writer: cursor tracking over the 40x30 grid, registered single-cycle
// cell writes, and a 1200-cycle clear sweep.
module console_writer
   import console_pkg::*;
#(
   parameter logic [3:0] BLANK_CODE     = 4'h0,
   parameter bit         CLEAR_ON_RESET = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   console_writer_if.slave  bus,
   output logic [4:0]       cursor_row,
   output logic [5:0]       cursor_col,
   output logic             busy,
   output logic [0:0]       fsm_state
);

   localparam logic [0:0]  S_IDLE   = 1'b0;
   localparam logic [0:0]  S_CLEAR  = 1'b1;
   localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);
   localparam logic [5:0]  LAST_COL = 6'(COLS - 1);
   localparam logic [10:0] SWEEP_END = 11'(CELLS);

   logic [0:0]  state;
   logic [10:0] sweep;
   logic [4:0]  row;
   logic [5:0]  col;
   logic        wr_q;
   logic [10:0] addr_q;
   logic [3:0]  wdata_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
         sweep   <= '0;
         row     <= '0;
         col     <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         wr_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  case (op_t'(bus.req_op))
                     OP_PUTC: begin
                        wr_q    <= 1'b1;
                        addr_q  <= cell_addr(row, col);
                        wdata_q <= bus.req_char;
                        if (col == LAST_COL) begin
                           col <= '0;
                           row <= (row == LAST_ROW) ? 5'd0 : row + 5'd1;
                        end else begin
                           col <= col + 6'd1;
                        end
                     end
                     OP_NEWLINE: begin
                        col <= '0;
                        row <= (row == LAST_ROW) ? 5'd0 : row + 5'd1;
                     end
                     OP_CLEAR: begin
                        // Cell 0 is written on the accept edge so the sweep
                        // occupies exactly the 1200 cycles after acceptance.
                        state   <= S_CLEAR;
                        wr_q    <= 1'b1;
                        addr_q  <= '0;
                        wdata_q <= BLANK_CODE;
                        sweep   <= 11'd1;
                     end
                     default: begin
                        row <= '0;
                        col <= '0;
                     end
                  endcase
               end
            end
            default: begin
               if (sweep == SWEEP_END) begin
                  state <= S_IDLE;
                  sweep <= '0;
                  row   <= '0;
                  col   <= '0;
               end else begin
                  wr_q    <= 1'b1;
                  addr_q  <= sweep;
                  wdata_q <= BLANK_CODE;
                  sweep   <= sweep + 11'd1;
               end
            end
         endcase
      end
   end

   assign bus.req_ready  = (state == S_IDLE);
   assign bus.smem_wr    = wr_q;
   assign bus.smem_addr  = addr_q;
   assign bus.smem_wdata = wdata_q;
   assign cursor_row     = row;
   assign cursor_col     = col;
   assign busy           = (state == S_CLEAR);
   assign fsm_state      = state;

endmodule

// File: tb/tb_console_writer.sv
// Self-checking bench for console_writer: expected writes (cycle, address, data)
// are queued by the drivers and compared by a write monitor on the falling edge.
module tb_console_writer;
   import console_pkg::*;

   localparam int         W     = 31;
   localparam logic [3:0] BLANK = 4'h0;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] cursor_row;
   logic [5:0] cursor_col;
   logic       busy;
   logic [0:0] fsm_state;

   console_writer_if bus();

   console_writer #(.BLANK_CODE(BLANK), .CLEAR_ON_RESET(1'b1)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .cursor_row (cursor_row),
      .cursor_col (cursor_col),
      .busy       (busy),
      .fsm_state  (fsm_state)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int wr_count = 0;
   int m_row    = 0;
   int m_col    = 0;
   logic [W-1:0] exp_q[$];

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] pack(input int c, input int a, input logic [3:0] d);
      return {16'(c), 11'(a), d};
   endfunction

   // Write monitor: every strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (bus.smem_wr === 1'b1) begin
         wr_count++;
         check("wr_pending", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0)
            check("wr", {1'b0, pack(cyc, int'(bus.smem_addr), bus.smem_wdata)},
                  {1'b0, exp_q.pop_front()});
      end
   end

   task automatic push_sweep(input int base);
      for (int k = 0; k < CELLS; k++) exp_q.push_back(pack(base + k, k, BLANK));
   endtask

   task automatic send(input logic [1:0] op, input logic [3:0] ch, output int acc_cyc);
      int n;
      n = 0;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_char  = ch;
      while (!bus.req_ready && n < 1400) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) begin
         check("accept_ready", 32'(bus.req_ready), 32'd1);
         bus.req_valid = 1'b0;
         acc_cyc = -1;
         return;
      end
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      acc_cyc = cyc;
      case (op)
         2'd0: begin
            exp_q.push_back(pack(cyc, m_row * 40 + m_col, ch));
            if (m_col == 39) begin
               m_col = 0;
               m_row = (m_row == 29) ? 0 : m_row + 1;
            end else begin
               m_col++;
            end
         end
         2'd1: begin
            m_col = 0;
            m_row = (m_row == 29) ? 0 : m_row + 1;
         end
         2'd2: begin
            push_sweep(cyc);
            m_row = 0;
            m_col = 0;
         end
         default: begin
            m_row = 0;
            m_col = 0;
         end
      endcase
   endtask

   task automatic wait_ready(output int rc);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.req_ready && n < 1300) begin
         @(negedge clk);
         n++;
      end
      check("ready_rise", 32'(bus.req_ready), 32'd1);
      rc = cyc;
   endtask

   task automatic check_cursor(input string tag, input int r, input int c);
      check({tag, "_row"}, 32'(cursor_row), 32'(r));
      check({tag, "_col"}, 32'(cursor_col), 32'(c));
   endtask

   task automatic goto_cell(input int r, input int c);
      int a;
      send(OP_HOME, 4'h0, a);
      for (int i = 0; i < r; i++) send(OP_NEWLINE, 4'h0, a);
      for (int i = 0; i < c; i++) send(OP_PUTC, 4'(i), a);
   endtask

   initial begin
      int base, rc, a1, a2, a3, t, n;
      bus.req_valid = 1'b0;
      bus.req_op    = 2'd0;
      bus.req_char  = 4'h0;
      reset         = 1'b1;

      // Power-on reset followed by the automatic clear sweep.
      repeat (3) @(negedge clk);
      check("rst_wr", 32'(bus.smem_wr), 32'd0);
      check("rst_addr", 32'(bus.smem_addr), 32'd0);
      check("rst_wdata", 32'(bus.smem_wdata), 32'd0);
      check("rst_ready", 32'(bus.req_ready), 32'd0);
      check_cursor("rst", 0, 0);
      reset = 1'b0;
      base = cyc + 1;
      push_sweep(base);
      wr_count = 0;
      wait_ready(rc);
      check("por_ready_cyc", 32'(rc), 32'(base + 1200));
      check("por_writes", 32'(wr_count), 32'd1200);
      check("por_busy", 32'(busy), 32'd0);
      check_cursor("por", 0, 0);

      // Back-to-back PUTCs from home.
      send(OP_HOME, 4'h0, a1);
      send(OP_PUTC, 4'h1, a1);
      send(OP_PUTC, 4'h2, a2);
      send(OP_PUTC, 4'h3, a3);
      check("b2b_span", 32'(a3 - a1), 32'd2);
      @(negedge clk);
      check_cursor("b2b", 0, 3);

      // Column wrap into the next row, then full-screen wrap.
      goto_cell(5, 39);
      @(negedge clk);
      check_cursor("pre_wrap", 5, 39);
      send(OP_PUTC, 4'h7, a1);
      @(negedge clk);
      check_cursor("col_wrap", 6, 0);
      goto_cell(29, 39);
      send(OP_PUTC, 4'h9, a1);
      @(negedge clk);
      check_cursor("scr_wrap", 0, 0);

      // NEWLINE on the last row and HOME from mid-screen.
      goto_cell(29, 12);
      send(OP_NEWLINE, 4'h0, a1);
      @(negedge clk);
      check_cursor("nl_wrap", 0, 0);
      goto_cell(10, 10);
      @(negedge clk);
      check_cursor("pre_home", 10, 10);
      send(OP_HOME, 4'h0, a1);
      @(negedge clk);
      check_cursor("home", 0, 0);

      // CLEAR with a PUTC held pending for the whole sweep.
      goto_cell(3, 4);
      send(OP_CLEAR, 4'h0, t);
      @(negedge clk);
      check("clr_busy", 32'(busy), 32'd1);
      check("clr_ready", 32'(bus.req_ready), 32'd0);
      send(OP_PUTC, 4'h5, a1);
      check("clr_putc_cyc", 32'(a1), 32'(t + 1201));
      @(negedge clk);
      check_cursor("clr_putc", 0, 1);

      // Reset in the middle of a sweep restarts it from address 0.
      send(OP_CLEAR, 4'h0, t);
      n = 0;
      @(negedge clk);
      while (!(bus.smem_wr && bus.smem_addr == 11'd600) && n < 1300) begin
         @(negedge clk);
         n++;
      end
      check("mid_addr", 32'(bus.smem_addr), 32'd600);
      #1;
      reset = 1'b1;
      exp_q.delete();
      #1;
      check("mid_rst_wr", 32'(bus.smem_wr), 32'd0);
      check("mid_rst_addr", 32'(bus.smem_addr), 32'd0);
      check("mid_rst_wdata", 32'(bus.smem_wdata), 32'd0);
      check_cursor("mid_rst", 0, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      m_row = 0;
      m_col = 0;
      base = cyc + 1;
      push_sweep(base);
      wr_count = 0;
      wait_ready(rc);
      check("mid_ready_cyc", 32'(rc), 32'(base + 1200));
      check("mid_writes", 32'(wr_count), 32'd1200);
      check_cursor("mid_done", 0, 0);

      repeat (3) @(negedge clk);
      check("q_drain", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/console_writer.md
# console_writer

Text-mode console writer that fills the character screen memory scanned by the VGA display driver. It accepts character and control requests over a valid/ready handshake, keeps a row/column cursor over the 40x30 grid of 16x16-pixel cells, and issues single-cycle writes of 4-bit character codes into screen memory. It also runs a multi-cycle clear-screen sweep. It sits between the processor's memory-mapped console port and the write port of screen memory; the display driver owns the read port.

## Interface
Parameters:
- BLANK_CODE, 4'h0, character code written to every cell by clear
- CLEAR_ON_RESET, 1, when 1 a full clear sweep starts automatically after reset

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_op  input  2  0=PUTC, 1=NEWLINE, 2=CLEAR, 3=HOME
- req_char  input  4  character code for PUTC; ignored otherwise
- req_ready  output  1  block can accept a request this cycle
- smem_wr  output  1  screen-memory write strobe, one cycle per cell
- smem_addr  output  11  screen-memory cell address, row*40 + col
- smem_wdata  output  4  character code to write
- cursor_row  output  5  current row, 0..29
- cursor_col  output  6  current column, 0..39
- busy  output  1  clear sweep in progress

## Operation
- The block has two states, IDLE and CLEAR. req_ready = (state == IDLE) and is combinational from state only, not from req_valid.
- A request is accepted on a clk edge where req_valid && req_ready.
- PUTC:
  - Register a write of req_char at the current cursor's address.
  - Advance col. At col 39, wrap to col 0 and row+1.
  - At row 29 col 39, wrap to row 0 col 0. The screen does not scroll.
- NEWLINE: col=0 and row=row+1, with row 29 wrapping to 0. No write.
- HOME: row=0, col=0. No write.
- CLEAR:
  - Go to CLEAR and write BLANK_CODE to addresses 0..1199 in ascending order, one per cycle.
  - After writing address 1199, set the cursor to (0,0) and return to IDLE.
- Addresses are computed as {row,5'b0} + {row,3'b0} + col at 11 bits. They never exceed 1199.
- smem_wr, smem_addr and smem_wdata are registered. smem_wr is low in every cycle with no write.
- Reset, asynchronous, may arrive at any time including mid-sweep:
  - smem_wr=0, smem_addr=0, smem_wdata=0, cursor (0,0).
  - Internal sweep counter = 0.
  - state = CLEAR if CLEAR_ON_RESET, else IDLE.
- Reset during a sweep restarts the sweep from address 0; there is no partial resume.
- req_valid while req_ready=0 is ignored. The requester holds it until accepted.

## Timing
- PUTC accepted at edge T: smem_wr=1 with the old cursor's address and the data during cycle T+1. The cursor holds its new value from T+1.
- PUTC throughput is one per cycle. Back-to-back PUTCs produce consecutive write cycles with no bubble.
- NEWLINE and HOME take effect at the accept edge. smem_wr stays 0 for them.
- CLEAR accepted at edge T:
  - req_ready=0 and busy=1 from cycle T+1.
  - smem_wr=1 in cycles T+1..T+1200 with addresses 0..1199.
  - req_ready=1, busy=0 and cursor (0,0) in cycle T+1201.
- After reset release with CLEAR_ON_RESET=1: the sweep writes address 0 in the first cycle after the first clk edge following deassertion. The sweep lasts 1200 cycles.
- Total latency from accept to memory write is 1 cycle. The display driver may read the cell from T+2.

## Structure
- Shared package console_pkg holds:
  - COLS=40, ROWS=30, CELLS=1200
  - an op_t enum {OP_PUTC, OP_NEWLINE, OP_CLEAR, OP_HOME}
  - a function cell_addr(row, col) returning 11 bits; the display driver's address arithmetic uses the same function
- No sub-module: a single flat module with one always_ff for state, cursor, sweep counter and write registers, plus a combinational req_ready.

## Test plan
- Reset with CLEAR_ON_RESET=1, then idle: exactly 1200 writes, addresses 0..1199, data BLANK_CODE, req_ready low throughout; then req_ready=1, cursor (0,0).
- From HOME, PUTC codes 1,2,3 on consecutive cycles -> writes (addr 0,data 1), (1,2), (2,3) on three consecutive cycles; cursor (0,3).
- Cursor at (5,39), PUTC 7 -> write addr 239 data 7; cursor (6,0). Cursor at (29,39), PUTC 9 -> write addr 1199; cursor (0,0).
- Cursor (29,12), NEWLINE -> no write, cursor (0,0). HOME from (10,10) -> cursor (0,0), no write.
- CLEAR with req_valid held high carrying PUTC during the sweep -> PUTC not accepted until req_ready returns in cycle T+1201; its write then lands at addr 0.
- Assert reset at sweep address 600 -> outputs zero immediately; after release the sweep restarts at address 0 and completes all 1200 writes.
